// File: rtl/native_bus_pkg.sv
// Shared types and constants for the PicoRV32 native-bus decoder.
// The state enum, the bus widths, the default error read data and the
// region match helper live here so the top and the timeout counter agree.
package native_bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   // Read data returned on unmapped or timed-out accesses unless overridden
   localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // A region matches when the masked address equals its base
   function automatic logic addr_match(
      input logic [ADDR_W-1:0] addr,
      input logic [ADDR_W-1:0] base,
      input logic [ADDR_W-1:0] mask
   );
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/native_bus_timeout.sv
// BUSY-state watchdog for native_bus_decoder.
// Counts cycles while enabled; expired is raised during the cycle in which
// the count would reach TIMEOUT_CYCLES, so the FSM can abort at that edge.
// Only instantiated when NATIVE_BUS_TIMEOUT_EN is defined.
module native_bus_timeout
   import native_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [15:0] LIMIT_M1 = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count_reg;

   // Cycle counter: cleared outside BUSY, incremented every BUSY cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 16'd1;
      end
   end

   assign expired = enable && (count_reg == LIMIT_M1);

endmodule

// File: rtl/native_bus_decoder.sv
// Address decoder and response mux for the PicoRV32 native memory bus.
// Registers the decode, drives one slave valid at a time and returns the
// selected slave's read data with a one-cycle mem_ready pulse. Unmapped
// accesses complete with ERR_RDATA and set a sticky error flag.
// Optional build macro: NATIVE_BUS_TIMEOUT_EN adds a BUSY watchdog that
// aborts a stalled slave access after TIMEOUT_CYCLES with an error response.
module native_bus_decoder
   import native_bus_pkg::*;
#(
   parameter int unsigned                 NSLAVES        = 4,
   parameter logic [NSLAVES*ADDR_W-1:0]   ADDR_BASE      = {32'h0300_0000, 32'h0200_0000,
                                                            32'h0010_0000, 32'h0000_0000},
   parameter logic [NSLAVES*ADDR_W-1:0]   ADDR_MASK      = {32'hFF00_0000, 32'hFFFF_FFFF,
                                                            32'hFFF0_0000, 32'hFFFF_C000},
   parameter int unsigned                 TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0]           ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        mem_valid,
   output logic                        mem_ready,
   input  logic [ADDR_W-1:0]           mem_addr,
   input  logic [DATA_W-1:0]           mem_wdata,
   input  logic [STRB_W-1:0]           mem_wstrb,
   output logic [DATA_W-1:0]           mem_rdata,
   output logic [NSLAVES-1:0]          s_valid,
   input  logic [NSLAVES-1:0]          s_ready,
   input  logic [NSLAVES*DATA_W-1:0]   s_rdata,
   output logic [ADDR_W-1:0]           s_addr,
   output logic [DATA_W-1:0]           s_wdata,
   output logic [STRB_W-1:0]           s_wstrb,
   input  logic                        err_clr,
   output logic                        err_flag,
   output logic [ADDR_W-1:0]           err_addr
);

   localparam int unsigned SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

   // Reject unusable configurations at elaboration time
   generate
      if (NSLAVES < 1 || NSLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
         $error("native_bus_decoder: NSLAVES or TIMEOUT_CYCLES out of range");
      end
   endgenerate

   state_t              state_reg;
   logic [SEL_W-1:0]    sel_reg;
   logic                mem_ready_reg;
   logic [DATA_W-1:0]   mem_rdata_reg;
   logic [NSLAVES-1:0]  s_valid_reg;
   logic [ADDR_W-1:0]   s_addr_reg;
   logic [DATA_W-1:0]   s_wdata_reg;
   logic [STRB_W-1:0]   s_wstrb_reg;
   logic                err_flag_reg;
   logic [ADDR_W-1:0]   err_addr_reg;

   logic [NSLAVES-1:0]  hit_vec;
   logic                addr_hit;
   logic [SEL_W-1:0]    hit_sel;
   logic [DATA_W-1:0]   s_rdata_arr [NSLAVES];
   logic                sel_ready;
   logic [DATA_W-1:0]   sel_rdata;
   logic                timeout_expired;
   logic                err_event;
   logic [ADDR_W-1:0]   err_src_addr;

   // Per-region match against the live CPU address and per-slave data lanes
   generate
      for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_region
         assign hit_vec[gi]     = addr_match(mem_addr,
                                             ADDR_BASE[ADDR_W*gi +: ADDR_W],
                                             ADDR_MASK[ADDR_W*gi +: ADDR_W]);
         assign s_rdata_arr[gi] = s_rdata[DATA_W*gi +: DATA_W];
      end
   endgenerate

   // Priority encode the hits: scanning downwards lets the lowest index win
   always_comb begin
      addr_hit = 1'b0;
      hit_sel  = '0;
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            addr_hit = 1'b1;
            hit_sel  = SEL_W'(i);
         end
      end
   end

   assign sel_ready = s_ready[sel_reg];
   assign sel_rdata = s_rdata_arr[sel_reg];

`ifdef NATIVE_BUS_TIMEOUT_EN
   native_bus_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_reg != BUSY),
      .enable  (state_reg == BUSY),
      .expired (timeout_expired)
   );
`else
   assign timeout_expired = 1'b0;
`endif

   // An error completes this edge: unmapped request in IDLE, or a watchdog
   // abort in BUSY that the selected slave's ready did not beat
   always_comb begin
      err_event    = 1'b0;
      err_src_addr = s_addr_reg;
      if (state_reg == IDLE) begin
         err_event    = mem_valid && !addr_hit;
         err_src_addr = mem_addr;
      end else if (state_reg == BUSY) begin
         err_event    = !sel_ready && timeout_expired;
      end
   end

   // Transaction FSM with registered bus outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         sel_reg       <= '0;
         mem_ready_reg <= 1'b0;
         mem_rdata_reg <= '0;
         s_valid_reg   <= '0;
         s_addr_reg    <= '0;
         s_wdata_reg   <= '0;
         s_wstrb_reg   <= '0;
      end else begin
         mem_ready_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (mem_valid) begin
                  s_addr_reg  <= mem_addr;
                  s_wdata_reg <= mem_wdata;
                  s_wstrb_reg <= mem_wstrb;
                  if (addr_hit) begin
                     sel_reg     <= hit_sel;
                     s_valid_reg <= NSLAVES'(1) << hit_sel;
                     state_reg   <= BUSY;
                  end else begin
                     mem_rdata_reg <= ERR_RDATA;
                     mem_ready_reg <= 1'b1;
                     state_reg     <= RESP;
                  end
               end
            end
            BUSY: begin
               if (sel_ready) begin
                  mem_rdata_reg <= sel_rdata;
                  mem_ready_reg <= 1'b1;
                  s_valid_reg   <= '0;
                  state_reg     <= RESP;
               end else if (timeout_expired) begin
                  mem_rdata_reg <= ERR_RDATA;
                  mem_ready_reg <= 1'b1;
                  s_valid_reg   <= '0;
                  state_reg     <= RESP;
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Sticky error: a new error beats err_clr and keeps the first address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_flag_reg <= 1'b0;
         err_addr_reg <= '0;
      end else if (err_event) begin
         err_flag_reg <= 1'b1;
         if (!err_flag_reg) begin
            err_addr_reg <= err_src_addr;
         end
      end else if (err_clr) begin
         err_flag_reg <= 1'b0;
         err_addr_reg <= '0;
      end
   end

   assign mem_ready = mem_ready_reg;
   assign mem_rdata = mem_rdata_reg;
   assign s_valid   = s_valid_reg;
   assign s_addr    = s_addr_reg;
   assign s_wdata   = s_wdata_reg;
   assign s_wstrb   = s_wstrb_reg;
   assign err_flag  = err_flag_reg;
   assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_native_bus_decoder.sv
// Self-checking bench for native_bus_decoder: directed transactions, a
// transaction-level expectation model checked every cycle, plus literal
// checks pinning the documented latencies and error behaviour.
// Build with NATIVE_BUS_TIMEOUT_EN defined to also exercise the watchdog.
module tb_native_bus_decoder;

   localparam int NS = 4;
   localparam int TO = 8;
`ifdef NATIVE_BUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mem_valid = 1'b0;
   logic          mem_ready;
   logic [31:0]   mem_addr = '0;
   logic [31:0]   mem_wdata = '0;
   logic [3:0]    mem_wstrb = '0;
   logic [31:0]   mem_rdata;
   logic [NS-1:0] s_valid;
   logic [NS-1:0] s_ready = '0;
   logic [NS*32-1:0] s_rdata = '0;
   logic [31:0]   s_addr;
   logic [31:0]   s_wdata;
   logic [3:0]    s_wstrb;
   logic          err_clr = 1'b0;
   logic          err_flag;
   logic [31:0]   err_addr;

   native_bus_decoder #(
      .NSLAVES        (NS),
      .ADDR_BASE      ({32'h0300_0000, 32'h0200_0000, 32'h0010_0000, 32'h0000_0000}),
      .ADDR_MASK      ({32'hFF00_0000, 32'hFFFF_FFFF, 32'hFFF0_0000, 32'hFFFF_C000}),
      .TIMEOUT_CYCLES (TO),
      .ERR_RDATA      (ERR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_rdata   (s_rdata),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .err_clr   (err_clr),
      .err_flag  (err_flag),
      .err_addr  (err_addr)
   );

   always #5 clk = ~clk;

   // Memory map as the model sees it, one entry per slave index
   logic [31:0] base_a [NS] = '{32'h0000_0000, 32'h0010_0000, 32'h0200_0000, 32'h0300_0000};
   logic [31:0] mask_a [NS] = '{32'hFFFF_C000, 32'hFFF0_0000, 32'hFFFF_FFFF, 32'hFF00_0000};

   int checks = 0;
   int failures = 0;

   // Expected DUT state for the current cycle
   bit          chk_en = 1'b0;
   logic        exp_ready = 1'b0;
   logic [3:0]  exp_sv = '0;
   logic [31:0] exp_rdata = '0;
   logic [31:0] exp_saddr = '0;
   logic [31:0] exp_swdata = '0;
   logic [3:0]  exp_swstrb = '0;
   logic        exp_eflag = 1'b0;
   logic [31:0] exp_eaddr = '0;

   // Per-transaction observations
   int          cyc_idx = 0;
   int          ready_cyc = -1;
   int          ready_cnt = 0;
   logic [3:0]  sv_or = '0;
   logic [3:0]  wstrb_seen = '0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Lowest-index region whose masked address equals its base
   task automatic model_decode(input logic [31:0] addr, output bit hit, output int sel);
      hit = 1'b0;
      sel = 0;
      for (int i = 0; i < NS; i++) begin
         if (!hit && ((addr & mask_a[i]) == base_a[i])) begin
            hit = 1'b1;
            sel = i;
         end
      end
   endtask

   // Single compare process: DUT against the model every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         check32("mem_ready", {31'b0, mem_ready}, {31'b0, exp_ready});
         check32("s_valid", {28'b0, s_valid}, {28'b0, exp_sv});
         check32("mem_rdata", mem_rdata, exp_rdata);
         check32("err_flag", {31'b0, err_flag}, {31'b0, exp_eflag});
         check32("err_addr", err_addr, exp_eaddr);
         if (exp_sv != 4'b0) begin
            check32("s_addr", s_addr, exp_saddr);
            check32("s_wdata", s_wdata, exp_swdata);
            check32("s_wstrb", {28'b0, s_wstrb}, {28'b0, exp_swstrb});
         end
         if (mem_ready) begin
            ready_cnt++;
            if (ready_cyc < 0) ready_cyc = cyc_idx;
         end
         sv_or = sv_or | s_valid;
         if (|s_valid) wstrb_seen = s_wstrb;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc_idx++;
   endtask

   // One CPU transaction starting in an IDLE cycle; returns in the IDLE
   // cycle after RESP. delay = cycle (1 = first s_valid cycle) in which the
   // selected slave answers, 0 = never.
   task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input int delay, input logic [31:0] rd, input bit clr);
      bit hit;
      int sel;
      int e;
      bit to;
      bit err;
      logic [3:0] onehot;
      model_decode(addr, hit, sel);
      onehot = 4'(1 << sel);
      cyc_idx = 0; ready_cyc = -1; ready_cnt = 0; sv_or = '0; wstrb_seen = '0;
      mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; err_clr = clr;
      s_ready = '0;
      exp_ready = 1'b0; exp_sv = '0;
      next_cycle();
      // CPU-side inputs change after sampling; the latched copy must hold
      mem_valid = 1'b0; mem_addr = ~addr; mem_wdata = ~wdata; mem_wstrb = ~wstrb; err_clr = 1'b0;
      to = 1'b0;
      if (hit) begin
         if (clr) begin
            exp_eflag = 1'b0;
            exp_eaddr = '0;
         end
         to = TO_EN && (delay == 0 || delay > TO);
         e = to ? TO : delay;
         exp_saddr = addr; exp_swdata = wdata; exp_swstrb = wstrb;
         for (int j = 1; j <= e; j++) begin
            exp_sv = onehot;
            exp_ready = 1'b0;
            for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = 32'hA5A5_0000 + 32'(i * 16 + j);
            s_rdata[32*sel +: 32] = rd;
            s_ready = ~onehot;
            if (!to && j == delay) s_ready = 4'hF;
            next_cycle();
         end
         s_ready = '0;
      end
      err = !hit || to;
      exp_sv = '0;
      exp_ready = 1'b1;
      exp_rdata = err ? ERR : rd;
      if (err) begin
         if (!exp_eflag) exp_eaddr = addr;
         exp_eflag = 1'b1;
      end
      next_cycle();
      exp_ready = 1'b0;
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      next_cycle();
      err_clr = 1'b0;
      exp_eflag = 1'b0;
      exp_eaddr = '0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check32("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
      check32("rst_s_valid", {28'b0, s_valid}, 32'd0);
      check32("rst_mem_rdata", mem_rdata, 32'd0);
      check32("rst_err_flag", {31'b0, err_flag}, 32'd0);
      check32("rst_err_addr", err_addr, 32'd0);
      check32("rst_s_addr", s_addr, 32'd0);
      reset = 1'b0;
      chk_en = 1'b1;
      next_cycle();

      // Read slave 0, ready in the third s_valid cycle
      txn(32'h0000_0010, 32'h0, 4'b0000, 3, 32'h1234_5678, 1'b0);
      check32("t1_latency", 32'(ready_cyc), 32'd4);
      check32("t1_rdata", mem_rdata, 32'h1234_5678);
      check32("t1_only_s0", {28'b0, sv_or}, 32'h1);
      $display("txn read  0x00000010 rdata=%h latency=%0d", mem_rdata, ready_cyc);

      // Back-to-back write to slave 2, minimum latency
      txn(32'h0200_0000, 32'hCAFE_F00D, 4'b0011, 1, 32'h5555_AAAA, 1'b0);
      check32("t2_only_s2", {28'b0, sv_or}, 32'h4);
      check32("t2_wstrb", {28'b0, wstrb_seen}, 32'h3);
      check32("t2_ready_cnt", 32'(ready_cnt), 32'd1);
      check32("t2_latency", 32'(ready_cyc), 32'd2);
      $display("txn write 0x02000000 wstrb=0011 latency=%0d", ready_cyc);

      // Unmapped read
      txn(32'h0400_0000, 32'h0, 4'b0000, 1, 32'h0, 1'b0);
      check32("t3_latency", 32'(ready_cyc), 32'd1);
      check32("t3_rdata", mem_rdata, 32'hDEAD_BEEF);
      check32("t3_err_flag", {31'b0, err_flag}, 32'd1);
      check32("t3_err_addr", err_addr, 32'h0400_0000);
      check32("t3_no_s_valid", {28'b0, sv_or}, 32'h0);
      $display("txn miss  0x04000000 err_addr=%h", err_addr);

      // Second miss keeps the first address
      txn(32'h0500_0000, 32'h0, 4'b0000, 1, 32'h0, 1'b0);
      check32("t4_err_addr", err_addr, 32'h0400_0000);
      $display("txn miss  0x05000000 err_addr=%h", err_addr);

      // Region edges and the other slaves
      txn(32'h0000_3FFC, 32'h0, 4'b0000, 2, 32'h0BAD_F00D, 1'b0);
      check32("t5_s0_edge", {28'b0, sv_or}, 32'h1);
      $display("txn read  0x00003FFC rdata=%h", mem_rdata);
      txn(32'h0000_4000, 32'h1111_2222, 4'b1111, 1, 32'h0, 1'b0);
      check32("t5_s0_past_edge", mem_rdata, 32'hDEAD_BEEF);
      $display("txn miss  0x00004000 rdata=%h", mem_rdata);
      txn(32'h001F_FFF0, 32'h0, 4'b0000, 2, 32'h7777_1111, 1'b0);
      check32("t5_s1", {28'b0, sv_or}, 32'h2);
      $display("txn read  0x001FFFF0 rdata=%h", mem_rdata);
      txn(32'h03AB_CDEF, 32'h9999_0000, 4'b1000, 5, 32'h3333_4444, 1'b0);
      check32("t5_s3", {28'b0, sv_or}, 32'h8);
      $display("txn write 0x03ABCDEF latency=%0d", ready_cyc);

      // err_clr alongside a new miss: the error wins
      txn(32'h0600_0000, 32'h0, 4'b0000, 1, 32'h0, 1'b1);
      check32("t6_err_flag", {31'b0, err_flag}, 32'd1);
      check32("t6_err_addr", err_addr, 32'h0400_0000);
      $display("txn miss+clr 0x06000000 err_flag=%0d", err_flag);

      // err_clr alone
      clear_err();
      check32("t7_err_flag", {31'b0, err_flag}, 32'd0);
      check32("t7_err_addr", err_addr, 32'd0);
      $display("txn err_clr err_flag=%0d", err_flag);

      // New miss after clear loads the new address
      txn(32'h0700_0000, 32'h0, 4'b0000, 1, 32'h0, 1'b0);
      check32("t8_err_addr", err_addr, 32'h0700_0000);
      clear_err();
      $display("txn miss  0x07000000 err_addr=%h", 32'h0700_0000);

`ifdef NATIVE_BUS_TIMEOUT_EN
      // Slave never ready: abort after TO BUSY cycles
      txn(32'h0000_0100, 32'h0, 4'b0000, 0, 32'h0, 1'b0);
      check32("t9_latency", 32'(ready_cyc), 32'd9);
      check32("t9_rdata", mem_rdata, 32'hDEAD_BEEF);
      check32("t9_err_flag", {31'b0, err_flag}, 32'd1);
      check32("t9_err_addr", err_addr, 32'h0000_0100);
      $display("txn timeout 0x00000100 rdata=%h", mem_rdata);
      clear_err();
      // Ready in the final allowed cycle beats the watchdog
      txn(32'h0000_0200, 32'h0, 4'b0000, 8, 32'h8888_0008, 1'b0);
      check32("t10_latency", 32'(ready_cyc), 32'd9);
      check32("t10_rdata", mem_rdata, 32'h8888_0008);
      check32("t10_err_flag", {31'b0, err_flag}, 32'd0);
      $display("txn ready@8 0x00000200 rdata=%h", mem_rdata);
`else
      // No watchdog: a long stall still completes normally
      txn(32'h0000_0200, 32'h0, 4'b0000, 20, 32'h8888_0020, 1'b0);
      check32("t10_latency", 32'(ready_cyc), 32'd21);
      check32("t10_rdata", mem_rdata, 32'h8888_0020);
      check32("t10_err_flag", {31'b0, err_flag}, 32'd0);
      $display("txn long stall 0x00000200 rdata=%h", mem_rdata);
`endif

      // Reset asserted while BUSY
      cyc_idx = 0; sv_or = '0;
      mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wdata = 32'h0; mem_wstrb = 4'b0;
      next_cycle();
      mem_valid = 1'b0;
      exp_sv = 4'b0001; exp_saddr = 32'h0000_0010; exp_swdata = 32'h0; exp_swstrb = 4'b0;
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      reset = 1'b1;
      #1;
      check32("rst_busy_s_valid", {28'b0, s_valid}, 32'd0);
      check32("rst_busy_mem_ready", {31'b0, mem_ready}, 32'd0);
      check32("rst_busy_rdata", mem_rdata, 32'd0);
      $display("txn reset-in-busy s_valid=%b", s_valid);
      next_cycle();
      reset = 1'b0;
      exp_sv = '0; exp_ready = 1'b0; exp_rdata = '0; exp_eflag = 1'b0; exp_eaddr = '0;
      chk_en = 1'b1;
      next_cycle();
      txn(32'h0010_0040, 32'h0, 4'b0000, 2, 32'h4242_4242, 1'b0);
      check32("t11_rdata", mem_rdata, 32'h4242_4242);
      check32("t11_only_s1", {28'b0, sv_or}, 32'h2);
      $display("txn read  0x00100040 after reset rdata=%h", mem_rdata);

      next_cycle();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
